// File: rtl/cook_sequencer.sv
// Microwave cook-run sequencer: whole-second countdown, 10 s magnetron duty window, pause/done handling.
// Optional feature macro COOK_BEEP_EN adds a `beep` output held for 3 ticks after completion.
module cook_sequencer #(
  parameter int unsigned CLK_PER_SEC = 1000,
  parameter int unsigned TIME_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_,
  input  logic              stop_,
  input  logic              clear_,
  input  logic              door_closed,
  input  logic              load,
  input  logic [TIME_W-1:0] load_secs,
  input  logic [3:0]        power,
  output logic              mag_on,
  output logic              timer_done,
  output logic [TIME_W-1:0] secs_left,
  output logic [1:0]        state
`ifdef COOK_BEEP_EN
  ,
  output logic              beep
`endif
);

  localparam int unsigned PRE_W = $clog2(CLK_PER_SEC);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COOK  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TIME_W-1:0] secs_q, secs_d;
  logic [3:0]        power_q, power_d;
  logic [3:0]        win_q, win_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              start_h_q, stop_h_q, clear_h_q;
  logic              mag_on_q, mag_on_d;
  logic              timer_done_q, timer_done_d;
`ifdef COOK_BEEP_EN
  logic [1:0]        beep_cnt_q, beep_cnt_d;
  logic              beep_q, beep_d;
`endif

  logic start_ev_c, stop_ev_c, clear_ev_c, key_ev_c, tick_c;

  // Falling-edge key events; history resets to 1 so a key held through reset is not an event
  assign start_ev_c = start_h_q & ~start_;
  assign stop_ev_c  = stop_h_q  & ~stop_;
  assign clear_ev_c = clear_h_q & ~clear_;
  assign key_ev_c   = start_ev_c | stop_ev_c | clear_ev_c;
  assign tick_c     = (pre_q == PRE_LAST);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      secs_q       <= '0;
      power_q      <= '0;
      win_q        <= '0;
      pre_q        <= '0;
      start_h_q    <= 1'b1;
      stop_h_q     <= 1'b1;
      clear_h_q    <= 1'b1;
      mag_on_q     <= 1'b0;
      timer_done_q <= 1'b0;
`ifdef COOK_BEEP_EN
      beep_cnt_q   <= '0;
      beep_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      secs_q       <= secs_d;
      power_q      <= power_d;
      win_q        <= win_d;
      pre_q        <= pre_d;
      start_h_q    <= start_;
      stop_h_q     <= stop_;
      clear_h_q    <= clear_;
      mag_on_q     <= mag_on_d;
      timer_done_q <= timer_done_d;
`ifdef COOK_BEEP_EN
      beep_cnt_q   <= beep_cnt_d;
      beep_q       <= beep_d;
`endif
    end
  end

  // Next state and datapath; a key event in the same cycle always suppresses load
  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    power_d = power_q;
    win_d   = win_q;
    pre_d   = pre_q;
    unique case (state_q)
      S_IDLE: begin
        if (clear_ev_c) begin
          secs_d = '0;
          win_d  = '0;
          pre_d  = '0;
        end else if (start_ev_c && !stop_ev_c && (secs_q != '0) && door_closed) begin
          state_d = S_COOK;
          pre_d   = '0;
        end else if (load && !key_ev_c) begin
          secs_d  = load_secs;
          power_d = power;
          win_d   = '0;
        end
      end
      S_COOK: begin
        if (clear_ev_c) begin
          state_d = S_IDLE;
          secs_d  = '0;
          win_d   = '0;
          pre_d   = '0;
        end else if (stop_ev_c || !door_closed) begin
          state_d = S_PAUSE;
        end else if (tick_c) begin
          pre_d  = '0;
          secs_d = secs_q - TIME_W'(1);
          win_d  = (win_q == 4'd9) ? 4'd0 : win_q + 4'd1;
          if (secs_q == TIME_W'(1)) state_d = S_DONE;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      S_PAUSE: begin
        if (clear_ev_c || stop_ev_c) begin
          state_d = S_IDLE;
          secs_d  = '0;
          win_d   = '0;
          pre_d   = '0;
        end else if (start_ev_c && door_closed) begin
          state_d = S_COOK;
        end
      end
      S_DONE: begin
        if (key_ev_c) begin
          state_d = S_IDLE;
          pre_d   = '0;
        end else if (load) begin
          state_d = S_IDLE;
          secs_d  = load_secs;
          power_d = power;
          win_d   = '0;
          pre_d   = '0;
        end
`ifdef COOK_BEEP_EN
        else begin
          pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
        end
`endif
      end
    endcase
  end

`ifdef COOK_BEEP_EN
  // Beep tick budget: loaded on DONE entry, spent on DONE ticks
  always_comb begin
    beep_cnt_d = beep_cnt_q;
    if (state_d != S_DONE)                     beep_cnt_d = '0;
    else if (state_q != S_DONE)                beep_cnt_d = 2'd3;
    else if (tick_c && (beep_cnt_q != '0))     beep_cnt_d = beep_cnt_q - 2'd1;
  end
`endif

  // Registered outputs derived from the next state
  always_comb begin
    mag_on_d     = (state_d == S_COOK) && (win_d < power_d);
    timer_done_d = (state_d == S_DONE);
`ifdef COOK_BEEP_EN
    beep_d       = (state_d == S_DONE) && (beep_cnt_d != '0);
`endif
  end

  assign mag_on     = mag_on_q;
  assign timer_done = timer_done_q;
  assign secs_left  = secs_q;
  assign state      = state_q;
`ifdef COOK_BEEP_EN
  assign beep       = beep_q;
`endif

endmodule

// File: tb/tb_cook_sequencer.sv
// Self-checking bench for cook_sequencer: directed scenarios plus randomized keys/door/load
// checked every cycle against a cooked-time model (remaining time derived from total cooking cycles).
module tb_cook_sequencer;

  localparam int CPS = 4;
  localparam int TW  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_ = 1'b1, stop_ = 1'b1, clear_ = 1'b1;
  logic          door_closed = 1'b1;
  logic          load = 1'b0;
  logic [TW-1:0] load_secs = '0;
  logic [3:0]    power = '0;
  logic          mag_on, timer_done;
  logic [TW-1:0] secs_left;
  logic [1:0]    state;
`ifdef COOK_BEEP_EN
  logic          beep;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  cook_sequencer #(.CLK_PER_SEC(CPS), .TIME_W(TW)) dut (
    .clk(clk), .rst(rst), .start_(start_), .stop_(stop_), .clear_(clear_),
    .door_closed(door_closed), .load(load), .load_secs(load_secs), .power(power),
    .mag_on(mag_on), .timer_done(timer_done), .secs_left(secs_left), .state(state)
`ifdef COOK_BEEP_EN
    , .beep(beep)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining time = loaded - cooked_cycles / CPS; window slot = (cooked_cycles / CPS) % 10
  int m_state, m_loaded, m_pow, m_cook, m_done_cyc;
  bit m_ps, m_pt, m_pc;

  function automatic int m_secs();
    return m_loaded - m_cook / CPS;
  endfunction

  function automatic int m_win();
    return (m_cook / CPS) % 10;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_loaded = 0; m_pow = 0; m_cook = 0; m_done_cyc = 0;
      m_ps = 1; m_pt = 1; m_pc = 1;
    end else begin
      bit sev, tev, cev, kev;
      sev = m_ps && !start_;
      tev = m_pt && !stop_;
      cev = m_pc && !clear_;
      kev = sev || tev || cev;
      case (m_state)
        0: begin
          if (cev) begin m_loaded = 0; m_cook = 0; end
          else if (sev && !tev && m_secs() > 0 && door_closed) m_state = 1;
          else if (load && !kev) begin m_loaded = int'(load_secs); m_pow = int'(power); m_cook = 0; end
        end
        1: begin
          if (cev) begin m_state = 0; m_loaded = 0; m_cook = 0; end
          else if (tev || !door_closed) m_state = 2;
          else begin
            m_cook++;
            if (m_secs() == 0) begin m_state = 3; m_done_cyc = 0; end
          end
        end
        2: begin
          if (cev || tev) begin m_state = 0; m_loaded = 0; m_cook = 0; end
          else if (sev && door_closed) m_state = 1;
        end
        default: begin
          if (kev) m_state = 0;
          else if (load) begin m_state = 0; m_loaded = int'(load_secs); m_pow = int'(power); m_cook = 0; end
          else m_done_cyc++;
        end
      endcase
      m_ps = start_; m_pt = stop_; m_pc = clear_;
    end
  end

  // Single compare process, away from the active edge
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("state", int'(state), m_state);
      check("secs_left", int'(secs_left), m_secs());
      check("mag_on", int'(mag_on), int'(m_state == 1 && m_win() < m_pow));
      check("timer_done", int'(timer_done), int'(m_state == 3));
`ifdef COOK_BEEP_EN
      check("beep", int'(beep), int'(m_state == 3 && m_done_cyc < 3 * CPS));
`endif
    end
  end

  task automatic press_start(); start_ = 1'b0; @(negedge clk); start_ = 1'b1; endtask
  task automatic press_stop();  stop_  = 1'b0; @(negedge clk); stop_  = 1'b1; endtask
  task automatic press_clear(); clear_ = 1'b0; @(negedge clk); clear_ = 1'b1; endtask
  task automatic do_load(input int s, input int p);
    load = 1'b1; load_secs = TW'(s); power = 4'(p);
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cnt, n;
    bit hist [0:199];
    repeat (3) @(negedge clk);
    check("reset_state", int'(state), 0);
    check("reset_mag", int'(mag_on), 0);
    check("reset_secs", int'(secs_left), 0);
    check("reset_done", int'(timer_done), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Full power, 3 s
    do_load(3, 10);
    press_start();
    cnt = 0;
    for (int i = 0; i < 40 && !timer_done; i++) begin
      if (mag_on) cnt++;
      @(negedge clk);
    end
    check("full_mag_cycles", cnt, 12);
    check("full_done", int'(timer_done), 1);
    check("full_secs", int'(secs_left), 0);
    check("full_mag_off", int'(mag_on), 0);
    check("full_state", int'(state), 3);
`ifdef COOK_BEEP_EN
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (beep) cnt++;
      @(negedge clk);
    end
    check("beep_cycles", cnt, 12);
`endif
    press_clear();
    check("done_clear_idle", int'(state), 0);

    // Duty cycle, 20 s at power 3
    do_load(20, 3);
    press_start();
    cnt = 0; n = 0;
    for (int i = 0; i < 200 && !timer_done; i++) begin
      hist[i] = mag_on;
      if (mag_on) cnt++;
      n++;
      @(negedge clk);
    end
    check("duty_on_cycles", cnt, 24);
    check("duty_cook_cycles", n, 80);
    check("duty_sec0", int'(hist[0]), 1);
    check("duty_sec3", int'(hist[12]), 0);
    check("duty_sec9", int'(hist[39]), 0);
    check("duty_sec10", int'(hist[40]), 1);
    do_load(5, 10);
    check("done_load_state", int'(state), 0);
    check("done_load_secs", int'(secs_left), 5);

    // Door opened at second 2 of 5
    press_start();
    repeat (8) @(negedge clk);
    check("door_pre_secs", int'(secs_left), 3);
    door_closed = 1'b0;
    @(negedge clk);
    check("door_pause", int'(state), 2);
    check("door_mag", int'(mag_on), 0);
    check("door_secs", int'(secs_left), 3);
    door_closed = 1'b1;
    @(negedge clk);
    press_start();
    check("resume_state", int'(state), 1);
    n = 0;
    for (int i = 0; i < 100 && !timer_done; i++) begin
      n++;
      @(negedge clk);
    end
    check("resume_cycles", n, 12);
    check("resume_done", int'(timer_done), 1);
    press_clear();

    // Start refused: door open, then zero time
    do_load(4, 5);
    door_closed = 1'b0;
    press_start();
    repeat (3) @(negedge clk);
    check("door_open_idle", int'(state), 0);
    check("door_open_mag", int'(mag_on), 0);
    door_closed = 1'b1;
    press_clear();
    check("clear_secs", int'(secs_left), 0);
    press_start();
    @(negedge clk);
    check("zero_secs_idle", int'(state), 0);

    // Clear plus start in PAUSE, then a held start key
    do_load(6, 10);
    press_start();
    press_stop();
    check("stop_pause", int'(state), 2);
    clear_ = 1'b0; start_ = 1'b0;
    @(negedge clk);
    clear_ = 1'b1; start_ = 1'b1;
    check("clr_start_state", int'(state), 0);
    check("clr_start_secs", int'(secs_left), 0);
    do_load(6, 10);
    start_ = 1'b0;
    repeat (5) @(negedge clk);
    check("held_cook", int'(state), 1);
    press_stop();
    repeat (14) @(negedge clk);
    check("held_one_event", int'(state), 2);
    start_ = 1'b1;
    @(negedge clk);
    press_clear();

    // Asynchronous reset while cooking
    do_load(5, 10);
    press_start();
    repeat (3) @(negedge clk);
    check("pre_rst_mag", int'(mag_on), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_mag", int'(mag_on), 0);
    check("async_rst_secs", int'(secs_left), 0);
    check("async_rst_state", int'(state), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized keys, door and loads
    for (int i = 0; i < 4000; i++) begin
      start_      = ($urandom_range(0, 99) < 15) ? 1'b0 : 1'b1;
      stop_       = ($urandom_range(0, 99) < 3)  ? 1'b0 : 1'b1;
      clear_      = ($urandom_range(0, 99) < 2)  ? 1'b0 : 1'b1;
      door_closed = ($urandom_range(0, 99) < 4)  ? 1'b0 : 1'b1;
      load        = ($urandom_range(0, 99) < 6)  ? 1'b1 : 1'b0;
      load_secs   = TW'($urandom_range(0, 12));
      power       = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    start_ = 1'b1; stop_ = 1'b1; clear_ = 1'b1; door_closed = 1'b1; load = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
